// File: rtl/vga_frame_capture.sv
// Purpose : capture one rectangular window of a VGA h/v-sync + RGB stream into a frame-buffer SRAM write port.
// Latency : wr_en/wr_addr/wr_data appear one clk after the pix_en cycle that hit the window; done one clk after the last write.
// Backpressure: none -- the SRAM write port is assumed always ready; pix_en low freezes counters and FSM.
//
// Ports: clk/reset (async, active-low); pix_en, h_sync_in, v_sync_in, red_in/green_in/blue_in from the video source;
//        start/busy/done/frame_err capture control and status; wr_en/wr_addr/wr_data SRAM write port.
// Optional build macro VGA_CAP_GRAY_EN: when defined, wr_data is a luma approximation (r + 2g + b) / 4
// instead of the red channel.
module vga_frame_capture #(
    parameter int CNT_W  = 10,
    parameter int WIN_H0 = 270,
    parameter int WIN_V0 = 52,
    parameter int WIN_W  = 300,
    parameter int WIN_H  = 300,
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en,
    input  logic              h_sync_in,
    input  logic              v_sync_in,
    input  logic [7:0]        red_in,
    input  logic [7:0]        green_in,
    input  logic [7:0]        blue_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  H_LO     = CNT_W'(WIN_H0);
    localparam logic [CNT_W-1:0]  H_HI     = CNT_W'(WIN_H0 + WIN_W - 1);
    localparam logic [CNT_W-1:0]  V_LO     = CNT_W'(WIN_V0);
    localparam logic [CNT_W-1:0]  V_HI     = CNT_W'(WIN_V0 + WIN_H - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIN_W * WIN_H - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic              h_prev, v_prev;
    logic [CNT_W-1:0]  h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt;
    logic [ADDR_W-1:0] pix_idx;
    logic [DATA_W-1:0] pix_val;
    logic              h_rise, v_rise, win_hit, abort, cap_wr, accept;

    // Edges are only meaningful on pixel strobes; the history only advances on pix_en.
    assign h_rise = h_sync_in & ~h_prev;
    assign v_rise = v_sync_in & ~v_prev;

    always_comb begin
        h_cnt_nxt = h_rise ? '0 : ((h_cnt == CNT_MAX) ? h_cnt : h_cnt + 1'b1);
        if (v_rise)
            v_cnt_nxt = '0;
        else if (h_rise)
            v_cnt_nxt = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + 1'b1;
        else
            v_cnt_nxt = v_cnt;
    end

    // Window test uses the post-update counter values of this strobe.
    assign win_hit = pix_en && (h_cnt_nxt >= H_LO) && (h_cnt_nxt <= H_HI)
                            && (v_cnt_nxt >= V_LO) && (v_cnt_nxt <= V_HI);

    assign accept = (state_q == IDLE) && start;
    assign abort  = (state_q == CAPTURE) && pix_en && v_rise;
    assign cap_wr = (state_q == CAPTURE) && win_hit && !v_rise;

`ifdef VGA_CAP_GRAY_EN
    logic [9:0] gray_sum;
    assign gray_sum = {2'b00, red_in} + {1'b0, green_in, 1'b0} + {2'b00, blue_in};
    assign pix_val  = DATA_W'(gray_sum[9:2]);
`else
    logic unused_gb;
    assign unused_gb = ^{green_in, blue_in};
    assign pix_val   = DATA_W'(red_in);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_prev <= 1'b0;
            v_prev <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else if (pix_en) begin
            h_prev <= h_sync_in;
            v_prev <= v_sync_in;
            h_cnt  <= h_cnt_nxt;
            v_cnt  <= v_cnt_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ARMED;
            ARMED:   if (pix_en && v_rise) state_d = CAPTURE;
            CAPTURE: begin
                if (abort)
                    state_d = IDLE;
                else if (cap_wr && (pix_idx == LAST_IDX))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == ARMED) || (state_q == CAPTURE);
        done = (state_q == DONE);
    end

    // Write port and status; address is a running raster index, so no multiplier is needed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pix_idx   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                frame_err <= 1'b0;
                pix_idx   <= '0;
            end
            if (abort)
                frame_err <= 1'b1;
            if (cap_wr) begin
                wr_en   <= 1'b1;
                wr_addr <= pix_idx;
                wr_data <= pix_val;
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receive side of the VGA pixel interface: samples an incoming h_sync/v_sync/RGB stream and writes a rectangular window of one frame into a frame-buffer SRAM through a write port.
- Sits between a video source (or the display timing generator, looped back for self-test) and the image SRAM that the display path later reads.
- Captures exactly one frame per start request, then reports completion.

Parameters:
- CNT_W, 10, width of internal h/v counters (covers 800 x 525 timing)
- WIN_H0, 270, first captured horizontal count
- WIN_V0, 52, first captured vertical count
- WIN_W, 300, window width in pixels
- WIN_H, 300, window height in lines
- ADDR_W, 18, write address width
- DATA_W, 8, write data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel strobe: one clk-cycle pulse per pixel (25 MHz rate)
- h_sync_in  in  1  horizontal sync, active-high during sync pulse
- v_sync_in  in  1  vertical sync, active-high during sync pulse
- red_in  in  8  pixel red
- green_in  in  8  pixel green
- blue_in  in  8  pixel blue
- start  in  1  one-cycle capture request
- busy  out  1  high from accepted start until capture ends
- done  out  1  one-cycle pulse when the full window has been written
- frame_err  out  1  sticky: capture aborted by an early v_sync; cleared by the next accepted start
- wr_en  out  1  SRAM write strobe, one cycle per pixel
- wr_addr  out  ADDR_W  SRAM write address
- wr_data  out  DATA_W  SRAM write data

Behaviour:
- Reset (reset = 0, async): state IDLE; h_cnt = v_cnt = 0; sync history = 0; all outputs 0.
- Only pix_en cycles update the sync history and counters. Rising edge = sampled level 1 with previous sample 0.
- h_cnt:
  - 0 on an h_sync rising edge;
  - otherwise +1, saturating at 2^CNT_W-1.
- v_cnt:
  - 0 on a v_sync rising edge (takes priority over the h edge);
  - otherwise +1 on an h_sync rising edge, saturating.
- Window hit uses the counter values in effect after the update on that pix_en cycle: WIN_H0 <= h_cnt <= WIN_H0+WIN_W-1 and WIN_V0 <= v_cnt <= WIN_V0+WIN_H-1.
- FSM:
  - IDLE: start -> ARMED; busy = 1; frame_err = 0; pixel index = 0. start while busy is ignored.
  - ARMED: wait for a v_sync rising edge -> CAPTURE. No writes in ARMED.
  - CAPTURE: on each pix_en window hit, register one write. wr_en = 1 exactly one clk after that pix_en cycle. wr_addr = pixel index, which starts at 0 and increments after each write (raster order, no multiplier). wr_data is latched from the RGB sampled on the hit.
  - CAPTURE, last write: the write at index WIN_W*WIN_H-1 (89999) -> DONE.
  - CAPTURE, early v_sync: a v_sync rising edge in CAPTURE before the last write -> frame_err = 1, busy = 0, back to IDLE. done is not pulsed; an already-registered write still completes.
  - DONE: done = 1 and busy = 0 for one cycle -> IDLE.
- wr_en is 0 in every cycle that has no registered write. wr_addr/wr_data hold their last value while wr_en = 0.
- pix_en held low: counters and FSM freeze; outputs hold, except that wr_en and done stay single-cycle.
- Reset mid-capture: immediate return to reset state; no further writes; the partial frame in SRAM is left as is.
- Sync pulses wider than one pixel produce a single edge only.

Optional Feature:
- Macro: VGA_CAP_GRAY_EN
- Defined: wr_data = (red_in + 2*green_in + blue_in) >> 2, computed in 10 bits and truncated to 8; same one-cycle latency.
- Undefined: wr_data = red_in; green_in and blue_in are unused.

Test Plan:
- Reset asserted mid-stream with random inputs -> all outputs 0 immediately (async); after release, IDLE with no wr_en until start.
- start, then a full 800x525 frame from a reference timing generator with pixel value = (h+v) & 0xFF -> exactly 90000 wr_en pulses; first write addr 0, data (270+52)&0xFF = 0x42; last write addr 89999; one done pulse; busy low after.
- Frames streamed without start -> zero writes, done never asserted.
- start, then a second v_sync rising edge injected at line 100 -> frame_err = 1, no done, busy = 0, writes stop; next start clears frame_err.
- start pulsed again during CAPTURE -> ignored: write count and addresses unchanged, a single done.
- VGA_CAP_GRAY_EN defined, window pixel r = 200, g = 100, b = 40 -> wr_data = 110; undefined -> wr_data = 200.
